xsimbus_ram_slave: RTL and testbench

Bus responder (slave) for the xSimBus interconnect: it decodes the bus-selected device ID, accepts one read or write transaction at a time from the current bus master, and completes it against a local word-addressed RAM after a programmable number of wait states. It sits on the device side of xSimBus, one instance per RAM-backed device slot in the SoC. It is the counterpart of the xSimBus request/arbitration logic.

---
 rtl/xsimbus_pkg.sv | 24 ++
 rtl/xsimbus_ram_array.sv | 36 +++
 rtl/xsimbus_ram_slave.sv | 126 ++++++++++++
 tb/tb_xsimbus_ram_slave.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/xsimbus_pkg.sv
// Shared xSimBus definitions: bus widths, device-select constants and the
// responder state encoding.
package xsimbus_pkg;

  localparam int DEV_ID_W   = 5;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_ADDR_W = 32;
  localparam int BUS_BE_W   = BUS_DATA_W / 8;

  localparam logic DeviceSelect = 1'b1;
  localparam logic DeviceNotSel = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic dev_select(input logic req, input logic [DEV_ID_W-1:0] bus_id,
                                      input logic [DEV_ID_W-1:0] my_id);
    return (req && (bus_id == my_id)) ? DeviceSelect : DeviceNotSel;
  endfunction

endpackage

// File: rtl/xsimbus_ram_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module xsimbus_ram_array
  import xsimbus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [BUS_BE_W-1:0]   be_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [BUS_DATA_W-1:0] wdata_i,
  output logic [BUS_DATA_W-1:0] rdata_o
);

  logic [BUS_DATA_W-1:0] mem [DEPTH_WORDS];
  logic [BUS_DATA_W-1:0] rdata_q;

  // NOTE: the storage array and its read register carry no reset; contents
  // survive rst and the owner masks the read register until a real read.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < BUS_BE_W; i++) begin
          if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/xsimbus_ram_slave.sv
// xSimBus RAM responder: decodes its device ID, accepts one transaction at a
// time and completes it against the local RAM after WAIT_CYCLES wait states.
module xsimbus_ram_slave
  import xsimbus_pkg::*;
#(
  parameter int DEVICE_ID   = 0,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEV_ID_W-1:0]   device_id_in,
  input  logic                  req_in,
  input  logic                  we_in,
  input  logic [BUS_ADDR_W-1:0] addr_in,
  input  logic [BUS_BE_W-1:0]   be_in,
  input  logic [BUS_DATA_W-1:0] data_in,
  output logic [BUS_DATA_W-1:0] data_out,
  output logic                  ack_out,
  output logic                  err_out,
  output logic                  busy_out
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WAIT_INIT  = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e                state_q;
  logic [3:0]            wait_cnt_q;
  logic                  we_q;
  logic [BUS_ADDR_W-1:0] addr_q;
  logic [BUS_BE_W-1:0]   be_q;
  logic [BUS_DATA_W-1:0] wdata_q;
  logic                  ack_q, err_q, busy_q, zero_q;

  logic                  sel, enter_resp, cur_err, cur_we;
  logic [BUS_ADDR_W-1:0] cur_addr;
  logic [BUS_BE_W-1:0]   cur_be;
  logic [BUS_DATA_W-1:0] cur_wdata, ram_rdata;

  // With zero wait states the RAM is accessed on the accepting edge, so the
  // transaction fields come straight from the bus rather than the latches.
  // NOTE: every signal gets its value on every path through this block, so
  // no latches are inferred.
  always_comb begin
    sel        = dev_select(req_in, device_id_in, DEV_ID_W'(DEVICE_ID));
    cur_we     = (state_q == IDLE) ? we_in   : we_q;
    cur_addr   = (state_q == IDLE) ? addr_in : addr_q;
    cur_be     = (state_q == IDLE) ? be_in   : be_q;
    cur_wdata  = (state_q == IDLE) ? data_in : wdata_q;
    enter_resp = ((state_q == IDLE) && sel && (WAIT_CYCLES == 0)) ||
                 ((state_q == WAIT) && (wait_cnt_q == 4'd0));
    cur_err    = (cur_addr[1:0] != 2'b00) || ({1'b0, cur_addr} >= ADDR_LIMIT);
  end

  xsimbus_ram_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk     (clk),
    .en_i    (enter_resp && !cur_err),
    .we_i    (cur_we),
    .be_i    (cur_be),
    .addr_i  (cur_addr[AW+1:2]),
    .wdata_i (cur_wdata),
    .rdata_o (ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      ack_q <= enter_resp;
      err_q <= enter_resp && cur_err;
      if (enter_resp) begin
        if (cur_err)     zero_q <= 1'b1;
        else if (!cur_we) zero_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (sel) begin
            we_q    <= we_in;
            addr_q  <= addr_in;
            be_q    <= be_in;
            wdata_q <= data_in;
            busy_q  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_q <= RESP;
            end else begin
              state_q    <= WAIT;
              wait_cnt_q <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt_q == 4'd0) state_q <= RESP;
          else                    wait_cnt_q <= wait_cnt_q - 4'd1;
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // The read register is masked to zero after reset and after an erroring
  // transaction; writes leave both the mask and the register untouched.
  assign data_out = zero_q ? '0 : ram_rdata;
  assign ack_out  = ack_q;
  assign err_out  = err_q;
  assign busy_out = busy_q;

endmodule

// File: tb/tb_xsimbus_ram_slave.sv
// Directed bench for xsimbus_ram_slave: two responders (ID 3 with two wait
// states, ID 0 with none) on one shared bus, checked against a scoreboard.
module tb_xsimbus_ram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  device_id;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [31:0] dout3, dout0;
  logic        ack3, err3, busy3, ack0, err0, busy0;

  always #5 clk = ~clk;

  xsimbus_ram_slave #(.DEVICE_ID(3), .DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut3 (
    .clk(clk), .rst(rst), .device_id_in(device_id), .req_in(req), .we_in(we),
    .addr_in(addr), .be_in(be), .data_in(wdata), .data_out(dout3),
    .ack_out(ack3), .err_out(err3), .busy_out(busy3)
  );

  xsimbus_ram_slave #(.DEVICE_ID(0), .DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .device_id_in(device_id), .req_in(req), .we_in(we),
    .addr_in(addr), .be_in(be), .data_in(wdata), .data_out(dout0),
    .ack_out(ack0), .err_out(err0), .busy_out(busy0)
  );

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [2][64];
  logic [31:0] exp_dout [2];
  int          checks = 0;
  int          errors = 0;

  // Index 1 is the ID-3 responder, index 0 the zero-wait ID-0 responder.
  function automatic logic [4:0] id_of(int d);   return (d == 1) ? 5'd3 : 5'd0; endfunction
  function automatic int          wait_of(int d); return (d == 1) ? 2 : 0;       endfunction
  function automatic logic        ack_of(int d);  return (d == 1) ? ack3 : ack0;  endfunction
  function automatic logic        err_of(int d);  return (d == 1) ? err3 : err0;  endfunction
  function automatic logic        busy_of(int d); return (d == 1) ? busy3 : busy0; endfunction
  function automatic logic [31:0] dout_of(int d); return (d == 1) ? dout3 : dout0; endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_txn(input int d, input logic w, input logic [31:0] a,
                            input logic [3:0] b, input logic [31:0] dat);
    exp_t e;
    logic er;
    er = (a[1:0] != 2'b00) || (a >= 32'd256);
    if (er) begin
      exp_dout[d] = 32'h0;
    end else if (w) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) mdl[d][a[7:2]][8*i +: 8] = dat[8*i +: 8];
    end else begin
      exp_dout[d] = mdl[d][a[7:2]];
    end
    e.err  = er;
    e.data = exp_dout[d];
    sb.push_back(e);
  endtask

  task automatic drive(input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] dat);
    device_id = id_of(d);
    req       = 1'b1;
    we        = w;
    addr      = a;
    be        = b;
    wdata     = dat;
  endtask

  task automatic wait_ack(input int d, output int lat);
    int  k;
    logic got;
    k   = 0;
    got = 1'b0;
    while (!got && k < 30) begin
      @(negedge clk);
      k++;
      got = ack_of(d);
    end
    lat = got ? k : 99;
  endtask

  task automatic complete(input int d, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_err"},  64'(err_of(d)),  64'(e.err));
      check({tag, "_data"}, 64'(dout_of(d)), 64'(e.data));
    end
  endtask

  task automatic txn(input int d, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] dat, input string tag);
    int lat;
    @(negedge clk);
    drive(d, w, a, b, dat);
    expect_txn(d, w, a, b, dat);
    wait_ack(d, lat);
    req = 1'b0;
    check({tag, "_lat"},  64'(lat), 64'(wait_of(d) + 1));
    check({tag, "_busy"}, 64'(busy_of(d)), 64'd1);
    complete(d, tag);
    @(negedge clk);
    check({tag, "_ack_once"}, 64'(ack_of(d)), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acks;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; device_id = '0;
    exp_dout[0] = 32'h0;
    exp_dout[1] = 32'h0;
    repeat (2) @(negedge clk);
    check("rst0_dout", 64'(dout3), 64'd0);
    check("rst0_ack",  64'(ack3),  64'd0);
    check("rst0_err",  64'(err3),  64'd0);
    check("rst0_busy", 64'(busy3), 64'd0);
    check("rst0_z_ack", 64'(ack0), 64'd0);
    rst = 1'b0;

    txn(1, 1'b1, 32'h40, 4'hF, 32'hDEADBEEF, "wr40");
    txn(1, 1'b0, 32'h40, 4'hF, 32'h0,        "rd40");

    txn(1, 1'b1, 32'h08, 4'hF, 32'h11223344, "wr08");
    txn(1, 1'b1, 32'h08, 4'h5, 32'hAABBCCDD, "wr08_be");
    txn(1, 1'b0, 32'h08, 4'h0, 32'h0,        "rd08_be");
    txn(1, 1'b1, 32'h08, 4'h0, 32'hFFFFFFFF, "wr08_be0");
    txn(1, 1'b0, 32'h08, 4'h0, 32'h0,        "rd08_be0");

    txn(1, 1'b1, 32'h00,  4'hF, 32'h0BADF00D, "wr00");
    txn(1, 1'b0, 32'h06,  4'h0, 32'h0,        "rd06_misal");
    txn(1, 1'b1, 32'h100, 4'hF, 32'hFFFFFFFF, "wr_oob");
    txn(1, 1'b0, 32'h00,  4'h0, 32'h0,        "rd00_after_oob");

    // Wrong device ID: nobody may answer and RAM must stay intact.
    @(negedge clk);
    drive(1, 1'b1, 32'h40, 4'hF, 32'h12345678);
    device_id = 5'd4;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack3 || ack0) acks++;
    end
    check("nosel_acks", 64'(acks), 64'd0);
    check("nosel_busy", 64'(busy3), 64'd0);
    req = 1'b0;
    txn(1, 1'b0, 32'h40, 4'h0, 32'h0, "rd40_nosel");

    // Reset in the middle of a write's wait states.
    txn(1, 1'b1, 32'h10, 4'hF, 32'hCAFE0010, "wr10");
    @(negedge clk);
    drive(1, 1'b1, 32'h10, 4'hF, 32'h55555555);
    @(negedge clk);
    check("midrst_busy_pre", 64'(busy3), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_dout", 64'(dout3), 64'd0);
    check("midrst_ack",  64'(ack3),  64'd0);
    check("midrst_err",  64'(err3),  64'd0);
    check("midrst_busy", 64'(busy3), 64'd0);
    req = 1'b0;
    exp_dout[0] = 32'h0;
    exp_dout[1] = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    txn(1, 1'b0, 32'h10, 4'h0, 32'h0, "rd10_after_rst");

    // Request held one cycle past ack: a second identical read follows.
    @(negedge clk);
    drive(1, 1'b0, 32'h40, 4'h0, 32'h0);
    expect_txn(1, 1'b0, 32'h40, 4'h0, 32'h0);
    wait_ack(1, lat);
    check("b2b_first_lat", 64'(lat), 64'd3);
    complete(1, "b2b_first");
    expect_txn(1, 1'b0, 32'h40, 4'h0, 32'h0);
    @(negedge clk);
    check("b2b_gap_ack", 64'(ack3), 64'd0);
    wait_ack(1, lat);
    req = 1'b0;
    check("b2b_spacing", 64'(lat + 1), 64'd4);
    complete(1, "b2b_second");
    @(negedge clk);
    check("b2b_ack_once", 64'(ack3), 64'd0);

    // Zero-wait responder: ack one cycle after the request.
    txn(0, 1'b1, 32'h04, 4'hF, 32'h0F0F0F0F, "z_wr04");
    txn(0, 1'b0, 32'h04, 4'h0, 32'h0,        "z_rd04");
    txn(0, 1'b0, 32'h05, 4'h0, 32'h0,        "z_rd05_misal");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
